mdu_ctrl: RTL and testbench
===========================

Name: mdu_ctrl

Overview:
- Parametrised multi-cycle multiply/divide unit with its own sequencing control, replacing single-cycle HI/LO handling in the E stage.
- Accepts mult, multu, div, divu, mthi and mtlo from the E stage.
- Holds a busy counter whose latency depends on the operation, and owns the HI/LO registers.
- Exports busy so the hazard unit can stall subsequent MD-class instructions; exception flush suppresses issue.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..255.
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..255.
- CNT_W, 8, busy counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  an MD-class instruction is valid in E this cycle.
- op  in  3  operation code, using the MDU_* encodings.
- cancel  in  1  exception or interrupt flush; suppresses start in the same cycle.
- src_a  in  WIDTH  rs value (dividend / multiplicand / mthi-mtlo data).
- src_b  in  WIDTH  rt value (divisor / multiplier).
- busy  out  1  an operation is in flight.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (synchronous, active-high): busy=0, counter=0, hi=0, lo=0, pending result registers=0. Reset mid-operation aborts the operation; HI/LO are not updated.
- Accept condition: acc = start & ~cancel & ~busy.
  - start while busy is ignored; the hazard unit guarantees this never happens, and the bench asserts it.
  - start with an undefined op is ignored.
- mthi / mtlo: on the acc edge, hi (or lo) <= src_a. busy stays 0. No pending operation is affected.
- mult / multu / div / divu on the acc edge:
  - Result is computed from the operands sampled at that edge and stored in pending registers.
  - Counter loads MULT_CYCLES or DIV_CYCLES. busy is 1 from the next cycle.
- Each busy cycle the counter decrements.
  - On the edge where counter==1: hi/lo <= pending result, counter <= 0, busy <= 0.
  - busy is high for exactly N cycles; the new HI/LO are visible in the first cycle busy=0.
- FSM states:
  - IDLE -> RUN on acc with a mult/div op.
  - RUN -> RUN while counter>1.
  - RUN -> IDLE when counter==1.
  - Any state -> IDLE on reset.
  - cancel has no effect in RUN: an issued MD operation always completes.
- Arithmetic:
  - mult: 2*WIDTH signed product; hi = upper half, lo = lower half.
  - multu: same split, unsigned product.
  - div: lo = quotient truncated toward zero, hi = remainder, which takes the dividend's sign.
  - divu: unsigned quotient and remainder.
  - Divide by zero (all variants): lo = all ones, hi = src_a.
  - Signed overflow (most-negative / -1): lo = most-negative, hi = 0.
- Outputs hi, lo and busy come straight from registers; no combinational path from inputs.
- Stall rule for the hazard unit (external): stall an MD-class instruction or mfhi/mflo in E when busy | acc_prev.

Decomposition:
- Shared package/macro file holds:
  - 3-bit op encodings: MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MTHI=5, MDU_MTLO=6.
  - Default latency constants.
- The controller decode maps the instruction bus onto these encodings.
- One sub-module is natural: mdu_arith, a combinational block for the signed/unsigned product and quotient/remainder, including the divide-by-zero and overflow rules. Counter, FSM and HI/LO stay in mdu_ctrl.

Test Plan:
- mult, src_a=0xFFFFFFFF, src_b=2, defaults -> busy high exactly 5 cycles; after busy falls hi=0xFFFFFFFF, lo=0xFFFFFFFE; hi/lo unchanged while busy.
- multu with same operands -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles.
- div, src_a=0xFFFFFFF9 (-7), src_b=2 -> busy 10 cycles, then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Boundary divides:
  - divu 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
  - div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start+cancel same cycle with op=MDU_MTHI, src_a=0x1234 -> hi unchanged, busy 0.
- Next cycle, same op without cancel -> hi=0x1234, busy stays 0.
- Start div, then reset in 3rd busy cycle -> busy=0, hi=lo=0 next cycle; a following mult starts cleanly.

Source files
------------

// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multi-cycle multiply/divide unit:
// operation encodings, controller states and default latencies.
package mdu_ctrl_pkg;

  typedef enum logic [2:0] {
    MDU_NONE  = 3'd0,
    MDU_MULT  = 3'd1,
    MDU_MULTU = 3'd2,
    MDU_DIV   = 3'd3,
    MDU_DIVU  = 3'd4,
    MDU_MTHI  = 3'd5,
    MDU_MTLO  = 3'd6
  } mduOp_e;

  typedef enum logic {
    IDLE,
    RUN
  } mduState_e;

  localparam int unsigned DEF_MULT_CYCLES = 5;
  localparam int unsigned DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage to multiply/divide unit bus: issue request, operands and
// the architectural HI/LO plus busy returned to the pipeline.
interface mdu_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic             cancel;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, cancel, src_a, src_b,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, cancel, src_a, src_b,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational product and quotient/remainder for the MDU, including
// the divide-by-zero and signed-overflow result rules.
module mdu_arith
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  mduOp_e           op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hiRes,
  output logic [WIDTH-1:0] loRes
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] sProd, uProd;
  logic [WIDTH-1:0]   sQuo, sRem, uQuo, uRem;
  logic [WIDTH-1:0]   aSafe, bSafe;
  logic               divZero, divOvf;

  assign sProd = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign uProd = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign divZero = (b == '0);
  assign divOvf  = (a == MOST_NEG) && (b == '1);

  // Operands are sanitised so the raw dividers never see x/0 or MIN/-1;
  // those cases are overridden below anyway.
  assign bSafe = divZero ? WIDTH'(1) : b;
  assign aSafe = divOvf ? '0 : a;

  assign sQuo = $signed(aSafe) / $signed(bSafe);
  assign sRem = $signed(aSafe) % $signed(bSafe);
  assign uQuo = a / bSafe;
  assign uRem = a % bSafe;

  always_comb begin
    hiRes = '0;
    loRes = '0;
    case (op)
      MDU_MULT:  {hiRes, loRes} = sProd;
      MDU_MULTU: {hiRes, loRes} = uProd;
      MDU_DIV: begin
        if (divZero) begin
          hiRes = a;
          loRes = '1;
        end else if (divOvf) begin
          hiRes = '0;
          loRes = MOST_NEG;
        end else begin
          hiRes = sRem;
          loRes = sQuo;
        end
      end
      MDU_DIVU: begin
        if (divZero) begin
          hiRes = a;
          loRes = '1;
        end else begin
          hiRes = uRem;
          loRes = uQuo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide controller: accepts MD-class ops from E,
// holds busy for the op latency and owns the HI/LO registers.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
  parameter int unsigned CNT_W       = 8
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave mdu
);

  mduState_e        state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic             busyReg, busyNext;
  logic [WIDTH-1:0] hiReg, hiNext, loReg, loNext;
  logic [WIDTH-1:0] pendHi, pendHiNext, pendLo, pendLoNext;
  logic [WIDTH-1:0] resHi, resLo;
  mduOp_e           opDec;
  logic             acc;

  assign opDec = mduOp_e'(mdu.op);
  assign acc   = mdu.start & ~mdu.cancel & ~busyReg;

  mdu_arith #(.WIDTH(WIDTH)) uArith (
    .op    (opDec),
    .a     (mdu.src_a),
    .b     (mdu.src_b),
    .hiRes (resHi),
    .loRes (resLo)
  );

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    busyNext   = busyReg;
    hiNext     = hiReg;
    loNext     = loReg;
    pendHiNext = pendHi;
    pendLoNext = pendLo;
    case (state)
      IDLE: begin
        if (acc) begin
          case (opDec)
            MDU_MULT, MDU_MULTU: begin
              pendHiNext = resHi;
              pendLoNext = resLo;
              cntNext    = CNT_W'(MULT_CYCLES);
              busyNext   = 1'b1;
              stateNext  = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              pendHiNext = resHi;
              pendLoNext = resLo;
              cntNext    = CNT_W'(DIV_CYCLES);
              busyNext   = 1'b1;
              stateNext  = RUN;
            end
            MDU_MTHI: hiNext = mdu.src_a;
            MDU_MTLO: loNext = mdu.src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // Results retire on the last busy edge so they are visible
        // in the first cycle busy reads low.
        if (cnt == CNT_W'(1)) begin
          hiNext    = pendHi;
          loNext    = pendLo;
          cntNext   = '0;
          busyNext  = 1'b0;
          stateNext = IDLE;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busyReg <= 1'b0;
      hiReg   <= '0;
      loReg   <= '0;
      pendHi  <= '0;
      pendLo  <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      busyReg <= busyNext;
      hiReg   <= hiNext;
      loReg   <= loNext;
      pendHi  <= pendHiNext;
      pendLo  <= pendLoNext;
    end
  end

  assign mdu.busy = busyReg;
  assign mdu.hi   = hiReg;
  assign mdu.lo   = loReg;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases followed by random
// operations compared against an arithmetic reference model.
module tb_mdu_ctrl;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  logic [31:0] mHi, mLo;

  mdu_ctrl_if #(.WIDTH(32)) bus ();

  mdu_ctrl #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10),
    .CNT_W       (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: updates mHi/mLo for an accepted op, returns busy cycles.
  function automatic int unsigned refApply(input logic [2:0] o, input logic [31:0] a,
                                           input logic [31:0] b, input bit cnl);
    longint          p;
    longint unsigned up;
    int              q, r;
    if (cnl) return 0;
    case (o)
      3'd1: begin p = longint'($signed(a)) * longint'($signed(b)); {mHi, mLo} = p; return 5; end
      3'd2: begin up = 64'(a) * 64'(b); {mHi, mLo} = up; return 5; end
      3'd3: begin
        if (b == 32'd0) begin mLo = 32'hFFFF_FFFF; mHi = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin mLo = a; mHi = 32'd0; end
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          mLo = q;
          mHi = r;
        end
        return 10;
      end
      3'd4: begin
        if (b == 32'd0) begin mLo = 32'hFFFF_FFFF; mHi = a; end
        else begin mLo = a / b; mHi = a % b; end
        return 10;
      end
      3'd5: begin mHi = a; return 0; end
      3'd6: begin mLo = a; return 0; end
      default: return 0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge of the first idle cycle.
  task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input bit cnl);
    logic [31:0] oldHi, oldLo;
    int unsigned lat, n;
    check({tag, "_idle_at_issue"}, 32'(bus.busy), 32'd0);
    oldHi = mHi;
    oldLo = mLo;
    lat = refApply(o, a, b, cnl);
    bus.start  = 1'b1;
    bus.op     = o;
    bus.src_a  = a;
    bus.src_b  = b;
    bus.cancel = cnl;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.src_a  = $urandom;
    bus.src_b  = $urandom;
    n = 0;
    while (bus.busy === 1'b1 && n < 300) begin
      check({tag, "_hi_hold"}, bus.hi, oldHi);
      check({tag, "_lo_hold"}, bus.lo, oldLo);
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, lat);
    check({tag, "_hi"}, bus.hi, mHi);
    check({tag, "_lo"}, bus.lo, mLo);
  endtask

  function automatic logic [31:0] pickOperand();
    logic [31:0] specials [5];
    specials[0] = 32'd0;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h8000_0000;
    specials[3] = 32'd1;
    specials[4] = 32'h7FFF_FFFF;
    if ($urandom_range(3) == 0) return specials[$urandom_range(4)];
    return $urandom;
  endfunction

  initial begin
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.op     = 3'd0;
    bus.src_a  = '0;
    bus.src_b  = '0;
    reset      = 1'b1;
    mHi        = '0;
    mLo        = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_hi", bus.hi, 32'd0);
    check("reset_lo", bus.lo, 32'd0);

    runOp("mult_neg1x2", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    runOp("multu_max_x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    runOp("div_m7_2", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    runOp("divu_by0", 3'd4, 32'd7, 32'd0, 1'b0);
    runOp("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    runOp("mthi_cancel", 3'd5, 32'h0000_1234, 32'd0, 1'b1);
    runOp("mthi", 3'd5, 32'h0000_1234, 32'd0, 1'b0);
    runOp("mtlo", 3'd6, 32'hCAFE_F00D, 32'd0, 1'b0);

    // div aborted by reset during its third busy cycle
    check("abort_idle_at_issue", 32'(bus.busy), 32'd0);
    bus.start = 1'b1;
    bus.op    = 3'd3;
    bus.src_a = 32'd100;
    bus.src_b = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_cycle3", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mHi = '0;
    mLo = '0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_hi", bus.hi, 32'd0);
    check("abort_lo", bus.lo, 32'd0);
    runOp("mult_after_abort", 3'd1, 32'd12345, 32'hFFFF_FFFD, 1'b0);

    for (int i = 0; i < 40; i++) begin
      logic [2:0]  o;
      logic [31:0] a, b;
      bit          cnl;
      o   = 3'($urandom_range(7));
      a   = pickOperand();
      b   = pickOperand();
      cnl = ($urandom_range(7) == 0);
      runOp($sformatf("rnd%0d_op%0d", i, o), o, a, b, cnl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
